// File: rtl/fp_pkg.sv
// fp_pkg: shared single-precision constants, normalizer state encoding and the IEEE-754 packing helper
package fp_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int FP_W  = 1 + EXP_W + MAN_W;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [FP_W-1:0] FP_ZERO = '0;
    localparam logic [FP_W-1:0] FP_INF  = {1'b0, EXP_MAX, {MAN_W{1'b0}}};
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    function automatic logic [FP_W-1:0] fp_pack(input logic s, input logic [EXP_W-1:0] e,
                                                 input logic [MAN_W-1:0] f);
        return {s, e, f};
    endfunction
endpackage

// File: rtl/fp_normalizer.sv
// fp_normalizer: post-add renormalization, one mantissa shift per cycle, with zero flush,
// underflow flush and overflow saturation, delivered over a valid/ready handshake
module fp_normalizer #(
    parameter int EXP_W = fp_pkg::EXP_W,
    parameter int MAN_W = fp_pkg::MAN_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic [MAN_W+1:0]       in_mant,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic                   out_ovf,
    output logic                   out_unf,
    output logic [4:0]             out_shifts
);
    import fp_pkg::*;

    localparam logic [EXP_W-1:0] E_MAX = '1;
    localparam logic [EXP_W-1:0] E_ONE = EXP_W'(1);

    state_t               state_q, state_d;
    logic                 sign_q, sign_d;
    logic [EXP_W-1:0]     exp_q, exp_d;
    logic [MAN_W+1:0]     mant_q, mant_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [EXP_W+MAN_W:0] res_q, res_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic [4:0]           shifts_q, shifts_d;

    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q == DONE;
    assign out_result = res_q;
    assign out_ovf    = ovf_q;
    assign out_unf    = unf_q;
    assign out_shifts = shifts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            shifts_q <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            shifts_q <= shifts_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        shifts_d = shifts_q;
        case (state_q)
            IDLE: if (in_valid) begin
                sign_d  = in_sign;
                exp_d   = in_exp;
                mant_d  = in_mant;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                // Terminal rules share the flag/count update; only the carry and left-shift rules loop
                shifts_d = cnt_q;
                ovf_d    = 1'b0;
                unf_d    = 1'b0;
                state_d  = DONE;
                if (mant_q == '0) begin
                    res_d = FP_ZERO;
                end else if (exp_q == E_MAX) begin
                    res_d = fp_pack(sign_q, EXP_MAX, '0);
                    ovf_d = 1'b1;
                end else if (mant_q[MAN_W+1]) begin
                    mant_d   = mant_q >> 1;
                    exp_d    = exp_q + E_ONE;
                    shifts_d = shifts_q;
                    ovf_d    = ovf_q;
                    unf_d    = unf_q;
                    state_d  = SHIFT;
                end else if (mant_q[MAN_W]) begin
                    res_d = fp_pack(sign_q, exp_q, mant_q[MAN_W-1:0]);
                end else if (exp_q <= E_ONE) begin
                    res_d = FP_ZERO;
                    unf_d = 1'b1;
                end else begin
                    mant_d   = mant_q << 1;
                    exp_d    = exp_q - E_ONE;
                    cnt_d    = cnt_q + 5'd1;
                    shifts_d = shifts_q;
                    ovf_d    = ovf_q;
                    unf_d    = unf_q;
                    state_d  = SHIFT;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fp_normalizer.sv
// tb_fp_normalizer: directed vectors checked against an arithmetic normalization model plus pinned literals
module tb_fp_normalizer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [24:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_unf;
    logic [4:0]  out_shifts;

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;
    logic [31:0] exp_r;
    logic        exp_o, exp_u;
    int          exp_sh, exp_lat;

    always #5 clk = ~clk;

    fp_normalizer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_ovf(out_ovf), .out_unf(out_unf), .out_shifts(out_shifts)
    );

    // Closed-form result: find the leading one, then decide pack / flush / saturate from exponent headroom
    function automatic void model(input logic s, input logic [7:0] e, input logic [24:0] m,
                                  output logic [31:0] r, output logic o, output logic u,
                                  output int sh, output int lat);
        int ev;
        int p;
        int k;
        logic [24:0] mm;
        ev = int'(e);
        mm = m;
        r = 32'h0; o = 1'b0; u = 1'b0; sh = 0; lat = 2;
        if (mm == 0) return;
        if (ev == 255) begin
            r = {s, 8'hFF, 23'h0}; o = 1'b1; return;
        end
        if (mm[24]) begin
            ev = ev + 1; mm = mm >> 1; lat = 3;
            if (ev == 255) begin
                r = {s, 8'hFF, 23'h0}; o = 1'b1;
            end else r = {s, 8'(ev), mm[22:0]};
            return;
        end
        p = 0;
        for (int i = 0; i < 24; i++) if (mm[i]) p = i;
        k = 23 - p;
        if (ev - 1 >= k || k == 0) begin
            mm = mm << k;
            r = {s, 8'(ev - k), mm[22:0]}; sh = k; lat = k + 2;
        end else begin
            sh = ev > 1 ? ev - 1 : 0; u = 1'b1; lat = sh + 2;
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && armed && out_valid) begin
            checks++;
            if (out_result !== exp_r || out_ovf !== exp_o || out_unf !== exp_u || int'(out_shifts) != exp_sh) begin
                errors++;
                $display("FAIL result: got %h ovf%b unf%b sh%0d, want %h ovf%b unf%b sh%0d",
                         out_result, out_ovf, out_unf, out_shifts, exp_r, exp_o, exp_u, exp_sh);
            end
        end
    end

    task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] m, input bit hold);
        int n;
        model(s, e, m, exp_r, exp_o, exp_u, exp_sh, exp_lat);
        in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1; out_ready = !hold;
        armed = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!out_valid || n != exp_lat) begin
            errors++;
            $display("FAIL latency %h/%h: got %0d valid %b, want %0d", e, m, n, out_valid, exp_lat);
        end
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h80; in_mant = 25'h0800000;
                @(posedge clk); #1;
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL hold: in_ready %b out_valid %b, want 0 1", in_ready, out_valid);
                end
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        armed = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== exp_r) begin
            errors++;
            $display("FAIL release: valid %b ready %b res %h, want 0 1 %h", out_valid, in_ready, out_result, exp_r);
        end
    endtask

    task automatic pin(input logic s, input logic [7:0] e, input logic [24:0] m,
                       input logic [31:0] lr, input logic lo, input logic lu, input int lsh, input int llat);
        logic [31:0] r;
        logic o, u;
        int sh, lat;
        model(s, e, m, r, o, u, sh, lat);
        checks++;
        if (r !== lr || o !== lo || u !== lu || sh != lsh || lat != llat) begin
            errors++;
            $display("FAIL model %h/%h: got %h %b %b %0d %0d, want %h %b %b %0d %0d",
                     e, m, r, o, u, sh, lat, lr, lo, lu, lsh, llat);
        end
        run_op(s, e, m, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'h0 || out_ovf || out_unf || out_shifts !== 5'd0) begin
            errors++;
            $display("FAIL reset: ready %b valid %b res %h", in_ready, out_valid, out_result);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        pin(1'b0, 8'h80, 25'h0800000, 32'h40000000, 1'b0, 1'b0, 0, 2);
        pin(1'b0, 8'h80, 25'h1800000, 32'h40C00000, 1'b0, 1'b0, 0, 3);
        pin(1'b0, 8'h80, 25'h0000001, 32'h34800000, 1'b0, 1'b0, 23, 25);
        pin(1'b1, 8'h80, 25'h0000000, 32'h00000000, 1'b0, 1'b0, 0, 2);
        pin(1'b0, 8'h03, 25'h0000100, 32'h00000000, 1'b0, 1'b1, 2, 4);
        pin(1'b1, 8'hFE, 25'h1000000, 32'hFF800000, 1'b1, 1'b0, 0, 3);
        pin(1'b0, 8'h02, 25'h0400000, 32'h00800000, 1'b0, 1'b0, 1, 3);

        run_op(1'b1, 8'h7F, 25'h0C00000, 1'b0);
        run_op(1'b0, 8'h10, 25'h1FFFFFF, 1'b0);
        run_op(1'b0, 8'h00, 25'h0800000, 1'b0);
        run_op(1'b0, 8'h00, 25'h0000040, 1'b0);
        run_op(1'b1, 8'h01, 25'h0400000, 1'b0);
        run_op(1'b0, 8'hFF, 25'h0000005, 1'b0);
        run_op(1'b1, 8'h20, 25'h0012345, 1'b0);
        run_op(1'b0, 8'h81, 25'h1234567, 1'b1);

        in_sign = 1'b0; in_exp = 8'h80; in_mant = 25'h0000001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0) begin
            errors++;
            $display("FAIL async reset: valid %b ready %b res %h", out_valid, in_ready, out_result);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, 8'h80, 25'h1800000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
